// File: rtl/i2c_host_if.sv
// Register-mapped host front-end for the I2C master.
// Owns TX/RX FIFOs, strobe edge detect and the start/status FSM.
module i2c_host_if #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bus_wr,
  input  logic       bus_rd,
  input  logic [2:0] bus_addr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       i_ready,
  output logic [6:0] addr,
  output logic       rw,
  output logic [7:0] data_cnt,
  output logic [7:0] data_in,
  input  logic       i_txff_rd,
  output logic       i_txff_empty,
  input  logic [7:0] data_out,
  input  logic       i_rxff_wr,
  output logic       i_rxff_full,
  input  logic       i2c_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);

  logic [1:0]    state_q, state_d;
  logic          txrd_q, rxwr_q, dn_q;
  logic          tx_rise, tx_fall, rx_rise, dn_rise;
  logic [7:0]    slv_q, cnt_q;
  logic [6:0]    addr_q;
  logic          rw_q;
  logic [7:0]    dcnt_q;
  logic [7:0]    din_q;
  logic [7:0]    rdata_q, rdata_d;
  logic          err_q, done_q, txovf_q, rxovf_q;
  logic          err_set, done_set, latch;

  logic [7:0]    txm_q [DEPTH];
  logic [AW-1:0] txw_q, txr_q;
  logic [AW:0]   txc_q;
  logic [7:0]    rxm_q [DEPTH];
  logic [AW-1:0] rxw_q, rxr_q;
  logic [AW:0]   rxc_q;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_wr, tx_push, tx_pop;
  logic rx_push, rx_pop;
  logic st_rd, start, short_tx, busy;
  logic [7:0] status;

  assign tx_rise = i_txff_rd & ~txrd_q;
  assign tx_fall = ~i_txff_rd & txrd_q;
  assign rx_rise = i_rxff_wr & ~rxwr_q;
  assign dn_rise = i2c_done & ~dn_q;

  assign tx_full  = (txc_q == FULL);
  assign tx_empty = (txc_q == '0);
  assign rx_full  = (rxc_q == FULL);
  assign rx_empty = (rxc_q == '0);

  // A pop frees a slot, so a push into a full FIFO is accepted alongside it.
  assign tx_wr   = bus_wr && (bus_addr == 3'd2);
  assign tx_pop  = tx_fall && !tx_empty;
  assign tx_push = tx_wr && (!tx_full || tx_pop);
  assign rx_pop  = bus_rd && (bus_addr == 3'd3) && !rx_empty;
  assign rx_push = rx_rise && (!rx_full || rx_pop);

  assign st_rd    = bus_rd && (bus_addr == 3'd5);
  assign start    = bus_wr && (bus_addr == 3'd4) && bus_wdata[0];
  assign short_tx = !slv_q[0] && (9'(txc_q) < ({1'b0, cnt_q} + 9'd1));
  assign busy     = (state_q != S_IDLE);
  assign status   = {err_q, done_q, busy, txovf_q, rxovf_q,
                     tx_full, rx_empty, tx_empty};

  assign bus_rdata    = rdata_q;
  assign i_ready      = (state_q == S_REQ);
  assign addr         = addr_q;
  assign rw           = rw_q;
  assign data_cnt     = dcnt_q;
  assign data_in      = din_q;
  assign i_txff_empty = tx_empty;
  assign i_rxff_full  = rx_full;

  // Transfer sequencing: start check, address phase, data phase.
  always_comb begin
    state_d  = state_q;
    latch    = 1'b0;
    err_set  = 1'b0;
    done_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (short_tx) err_set = 1'b1;
          else begin
            latch   = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (start) err_set = 1'b1;
        if (dn_rise) begin
          state_d  = S_IDLE;
          done_set = 1'b1;
          err_set  = 1'b1;
        end else if (tx_rise) begin
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (start) err_set = 1'b1;
        if (dn_rise) begin
          state_d  = S_IDLE;
          done_set = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Host read data mux; RXDATA on an empty FIFO reads as zero.
  always_comb begin
    rdata_d = rdata_q;
    if (bus_rd) begin
      case (bus_addr)
        3'd0:    rdata_d = slv_q;
        3'd1:    rdata_d = cnt_q;
        3'd3:    rdata_d = rx_pop ? rxm_q[rxr_q] : 8'h00;
        3'd5:    rdata_d = status;
        default: rdata_d = 8'h00;
      endcase
    end
  end

  // FIFO storage, no reset needed.
  always_ff @(posedge clk) begin
    if (tx_push) txm_q[txw_q] <= bus_wdata;
    if (rx_push) rxm_q[rxw_q] <= data_out;
  end

  // Control state, pointers, counts and sticky status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      txrd_q  <= 1'b0;
      rxwr_q  <= 1'b0;
      dn_q    <= 1'b0;
      slv_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      dcnt_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      txovf_q <= 1'b0;
      rxovf_q <= 1'b0;
      txw_q   <= '0;
      txr_q   <= '0;
      txc_q   <= '0;
      rxw_q   <= '0;
      rxr_q   <= '0;
      rxc_q   <= '0;
    end else begin
      state_q <= state_d;
      txrd_q  <= i_txff_rd;
      rxwr_q  <= i_rxff_wr;
      dn_q    <= i2c_done;
      rdata_q <= rdata_d;
      if (bus_wr && bus_addr == 3'd0) slv_q <= bus_wdata;
      if (bus_wr && bus_addr == 3'd1) cnt_q <= bus_wdata;
      if (latch) begin
        addr_q <= slv_q[7:1];
        rw_q   <= slv_q[0];
        dcnt_q <= cnt_q;
      end
      if (!tx_empty) din_q <= txm_q[txr_q];
      err_q   <= err_set  | (err_q  & ~st_rd);
      done_q  <= done_set | (done_q & ~st_rd);
      txovf_q <= (tx_wr && !tx_push) | (txovf_q & ~st_rd);
      rxovf_q <= (rx_rise && !rx_push) | (rxovf_q & ~st_rd);
      if (tx_push) txw_q <= txw_q + 1'b1;
      if (tx_pop)  txr_q <= txr_q + 1'b1;
      if (tx_push && !tx_pop) txc_q <= txc_q + 1'b1;
      else if (tx_pop && !tx_push) txc_q <= txc_q - 1'b1;
      if (rx_push) rxw_q <= rxw_q + 1'b1;
      if (rx_pop)  rxr_q <= rxr_q + 1'b1;
      if (rx_push && !rx_pop) rxc_q <= rxc_q + 1'b1;
      else if (rx_pop && !rx_push) rxc_q <= rxc_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_host_if.sv
// Directed bench for i2c_host_if.
// Host bus tasks plus an inline master model.
module tb_i2c_host_if;

  logic       clk = 1'b0;
  logic       rst;
  logic       bus_wr, bus_rd;
  logic [2:0] bus_addr;
  logic [7:0] bus_wdata, bus_rdata;
  logic       i_ready, rw, i_txff_rd, i_txff_empty;
  logic [6:0] addr;
  logic [7:0] data_cnt, data_in, data_out;
  logic       i_rxff_wr, i_rxff_full, i2c_done;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] v;
  logic [7:0] exp_tx [3];

  i2c_host_if #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst),
    .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .i_ready(i_ready),
    .addr(addr), .rw(rw), .data_cnt(data_cnt),
    .data_in(data_in), .i_txff_rd(i_txff_rd),
    .i_txff_empty(i_txff_empty), .data_out(data_out),
    .i_rxff_wr(i_rxff_wr), .i_rxff_full(i_rxff_full),
    .i2c_done(i2c_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_wr = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_wr = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    bus_rd = 1'b1; bus_addr = a;
    @(negedge clk);
    bus_rd = 1'b0;
    d = bus_rdata;
  endtask

  task automatic done_pulse();
    @(negedge clk);
    i2c_done = 1'b1;
    cyc(3);
    i2c_done = 1'b0;
    cyc(2);
  endtask

  task automatic tx_strobe();
    @(negedge clk);
    i_txff_rd = 1'b1;
    cyc(2);
    i_txff_rd = 1'b0;
    cyc(3);
  endtask

  initial begin
    rst = 1'b0; bus_wr = 0; bus_rd = 0; bus_addr = 0; bus_wdata = 0;
    i_txff_rd = 0; data_out = 0; i_rxff_wr = 0; i2c_done = 0;
    exp_tx[0] = 8'h11; exp_tx[1] = 8'h22; exp_tx[2] = 8'h33;
    cyc(3);
    chk("rst_rdata", bus_rdata, 8'h00);
    chk("rst_ready", {7'd0, i_ready}, 8'h00);
    chk("rst_addr", {1'b0, addr}, 8'h00);
    chk("rst_rw", {7'd0, rw}, 8'h00);
    chk("rst_cnt", data_cnt, 8'h00);
    chk("rst_din", data_in, 8'h00);
    chk("rst_txe", {7'd0, i_txff_empty}, 8'h01);
    chk("rst_rxf", {7'd0, i_rxff_full}, 8'h00);
    @(negedge clk) rst = 1'b1;
    rd(3'd5, v); chk("st_idle", v, 8'h03);

    // Write transfer, three bytes
    wr(3'd0, 8'hA0); wr(3'd1, 8'h02);
    wr(3'd2, 8'h11); wr(3'd2, 8'h22); wr(3'd2, 8'h33);
    cyc(1);
    chk("w_head", data_in, 8'h11);
    wr(3'd4, 8'h01);
    chk("w_ready", {7'd0, i_ready}, 8'h01);
    chk("w_addr", {1'b0, addr}, 8'h50);
    chk("w_rw", {7'd0, rw}, 8'h00);
    chk("w_cnt", data_cnt, 8'h02);
    rd(3'd5, v); chk("w_busy", v, 8'h22);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i_txff_rd = 1'b1;
      chk("w_din_s", data_in, exp_tx[k]);
      cyc(4);
      chk("w_din_e", data_in, exp_tx[k]);
      if (k == 0) chk("w_rdy_lo", {7'd0, i_ready}, 8'h00);
      i_txff_rd = 1'b0;
      cyc(4);
    end
    done_pulse();
    // done | rx_empty | tx_empty
    rd(3'd5, v); chk("w_stat", v, 8'h43);
    chk("w_txe", {7'd0, i_txff_empty}, 8'h01);

    // Read transfer, two bytes
    wr(3'd0, 8'hA1); wr(3'd1, 8'h01); wr(3'd4, 8'h01);
    chk("r_ready", {7'd0, i_ready}, 8'h01);
    chk("r_rw", {7'd0, rw}, 8'h01);
    chk("r_cnt", data_cnt, 8'h01);
    tx_strobe();
    @(negedge clk) begin data_out = 8'h5A; i_rxff_wr = 1'b1; end
    cyc(20);
    i_rxff_wr = 1'b0;
    cyc(3);
    data_out = 8'hC3; i_rxff_wr = 1'b1;
    cyc(20);
    i_rxff_wr = 1'b0;
    cyc(2);
    done_pulse();
    rd(3'd5, v); chk("r_stat", v, 8'h41);
    rd(3'd3, v); chk("r_b0", v, 8'h5A);
    rd(3'd3, v); chk("r_b1", v, 8'hC3);
    rd(3'd3, v); chk("r_b2", v, 8'h00);
    rd(3'd5, v); chk("r_empty", v, 8'h03);

    // Write start with too few TX bytes
    wr(3'd0, 8'hA0); wr(3'd1, 8'h03);
    wr(3'd2, 8'hAA); wr(3'd2, 8'hBB);
    wr(3'd4, 8'h01);
    chk("e_ready0", {7'd0, i_ready}, 8'h00);
    cyc(3);
    chk("e_ready1", {7'd0, i_ready}, 8'h00);
    rd(3'd5, v); chk("e_stat", v, 8'h82);
    rd(3'd5, v); chk("e_clr", v, 8'h02);

    // Address NACK
    wr(3'd1, 8'h01); wr(3'd4, 8'h01);
    chk("n_ready", {7'd0, i_ready}, 8'h01);
    done_pulse();
    chk("n_rdy_lo", {7'd0, i_ready}, 8'h00);
    rd(3'd5, v); chk("n_stat", v, 8'hC2);
    rd(3'd5, v); chk("n_clr", v, 8'h02);
    tx_strobe(); tx_strobe();
    chk("n_drain", {7'd0, i_txff_empty}, 8'h01);

    // TX overflow and push/pop while full
    for (int i = 0; i < 16; i++) wr(3'd2, 8'h40 + 8'(i));
    rd(3'd5, v); chk("o_full", v, 8'h06);
    chk("o_head0", data_in, 8'h40);
    wr(3'd2, 8'h99);
    rd(3'd5, v); chk("o_ovf", v, 8'h16);
    chk("o_head1", data_in, 8'h40);
    @(negedge clk) i_txff_rd = 1'b1;
    @(negedge clk) begin
      i_txff_rd = 1'b0;
      bus_wr = 1'b1; bus_addr = 3'd2; bus_wdata = 8'hEE;
    end
    @(negedge clk) bus_wr = 1'b0;
    cyc(1);
    rd(3'd5, v); chk("o_pp", v, 8'h06);
    chk("o_head2", data_in, 8'h41);

    // Reset during the data phase
    wr(3'd0, 8'hA0); wr(3'd1, 8'h05); wr(3'd4, 8'h01);
    @(negedge clk) i_txff_rd = 1'b1;
    cyc(2);
    chk("x_xfer", {7'd0, i_ready}, 8'h00);
    chk("x_cnt", data_cnt, 8'h05);
    #3 rst = 1'b0;
    #1;
    chk("x_rdata", bus_rdata, 8'h00);
    chk("x_addr", {1'b0, addr}, 8'h00);
    chk("x_dcnt", data_cnt, 8'h00);
    chk("x_din", data_in, 8'h00);
    chk("x_txe", {7'd0, i_txff_empty}, 8'h01);
    chk("x_rxf", {7'd0, i_rxff_full}, 8'h00);
    i_txff_rd = 1'b0;
    @(negedge clk) rst = 1'b1;
    wr(3'd0, 8'hA0); wr(3'd1, 8'h00); wr(3'd2, 8'h77);
    wr(3'd4, 8'h01);
    chk("x_ready", {7'd0, i_ready}, 8'h01);
    chk("x_addr2", {1'b0, addr}, 8'h50);
    cyc(1);
    chk("x_din2", data_in, 8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
